// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register and a FETCH/WAIT/HALTED controller that issues
// variable-latency instruction-memory requests and hands words to the IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        instr_valid,
    output logic        flush_IFID,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] pc_r;
    logic [15:0] pc_next_s;
    logic [15:0] pc_plus2_s;
    logic        running_s;
    logic        req_s;
    logic        valid_s;
    logic        halt_word_s;

    // Datapath-level decode of the current cycle's request and response
    always_comb begin
        pc_plus2_s  = pc_r + 16'd2;
        running_s   = (state_r != HALTED) && !rst;
        req_s       = running_s && !stall && !branch_taken;
        valid_s     = req_s && imem_ready;
        halt_word_s = (imem_data[15:12] == HALT_OPCODE);
    end

    // Output drive; rst gating keeps every strobe low while reset is held
    always_comb begin
        imem_req     = req_s;
        imem_addr    = pc_r;
        pc_plus2_out = pc_plus2_s;
        instr_valid  = valid_s;
        flush_IFID   = running_s && branch_taken;
        halted       = (state_r == HALTED);
        if (valid_s) begin
            instr_out = imem_data;
        end else begin
            instr_out = 16'h0000;
        end
    end

    // Next-state and next-PC: branch > stall > ready > wait
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            FETCH, WAIT: begin
                if (branch_taken) begin
                    pc_next_s    = branch_target;
                    state_next_s = FETCH;
                end else if (stall) begin
                    // Request is dropped this cycle and reissued from FETCH later
                    state_next_s = FETCH;
                end else if (imem_ready) begin
                    if (halt_word_s) begin
                        state_next_s = HALTED;
                    end else begin
                        pc_next_s    = pc_plus2_s;
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                state_next_s = FETCH;
                pc_next_s    = RESET_PC;
            end
        endcase
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000: PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, 4'hF: opcode (instr[15:12]) that halts fetch.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port stall, input, 1: hazard hold; PC and fetch frozen.
REQ-006 Port branch_taken, input, 1: redirect fetch to branch_target this cycle.
REQ-007 Port branch_target, input, 16: redirect address.
REQ-008 Port imem_req, output, 1: instruction memory request.
REQ-009 Port imem_addr, output, 16: request address; always equals PC.
REQ-010 Port imem_ready, input, 1: imem_data valid this cycle; may lag imem_req by 0..N cycles.
REQ-011 Port imem_data, input, 16: returned instruction word.
REQ-012 Port instr_out, output, 16: instruction to the IF/ID register.
REQ-013 Port pc_plus2_out, output, 16: PC+2 of the delivered instruction, to the IF/ID register.
REQ-014 Port instr_valid, output, 1: instr_out/pc_plus2_out valid; IF/ID captures when high.
REQ-015 Port flush_IFID, output, 1: squash IF/ID contents.
REQ-016 Port halted, output, 1: fetch stopped on HALT_OPCODE.

Function
REQ-017 The block SHALL implement states FETCH, WAIT, HALTED, with state and PC registered.
REQ-018 The block SHALL drive imem_req=1 in FETCH and WAIT when stall=0 and branch_taken=0, else 0.
REQ-019 The block SHALL assert instr_valid combinationally = imem_req & imem_ready; instr_out = imem_data when valid, else 16'h0000.
REQ-020 The block SHALL drive pc_plus2_out = PC+2, modulo 2^16 (16'hFFFE+2 = 16'h0000).
REQ-021 Edge priority (FETCH/WAIT) SHALL be: branch_taken > stall > imem_ready > wait.
REQ-022 On branch_taken: PC<=branch_target, state<=FETCH; any concurrent imem_ready data is discarded.
REQ-023 On stall (no branch): PC held, state<=FETCH; the outstanding request is cancelled (imem_req=0) and reissued after stall drops.
REQ-024 On imem_ready with imem_data[15:12]!=HALT_OPCODE: PC<=PC+2, state<=FETCH; zero-wait back-to-back fetch gives one instruction per cycle.
REQ-025 On imem_ready with imem_data[15:12]==HALT_OPCODE: the halt word is delivered once (instr_valid=1), PC held, state<=HALTED.
REQ-026 With imem_req=1 and imem_ready=0: state<=WAIT, PC and imem_addr held.
REQ-027 flush_IFID SHALL equal branch_taken when state!=HALTED, else 0 (combinational).
REQ-028 In HALTED: imem_req=0, instr_valid=0, flush_IFID=0, halted=1; stall and branch_taken ignored; exit only via rst.
REQ-029 Dropping imem_req SHALL be the sole abort mechanism; no response is accepted without imem_req=1 in the same cycle.

Reset
REQ-030 While rst=1 (asynchronous assertion, mid-WAIT included): PC=RESET_PC, state=FETCH, halted=0, imem_req=0, instr_valid=0, flush_IFID=0, instr_out=16'h0000.
REQ-031 The first request SHALL issue at imem_addr=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-032 Zero-wait memory, 4 non-halt words from 0x0000 -> instr_valid=1 four consecutive cycles; imem_addr 0x0000,0x0002,0x0004,0x0006; pc_plus2_out 0x0002..0x0008.
REQ-033 imem_ready held low 3 cycles at PC=0x0010 -> imem_req=1, imem_addr=0x0010 throughout WAIT; PC advances to 0x0012 only after ready.
REQ-034 branch_taken=1, branch_target=0x0100, stall=1 and imem_ready=1 in the same cycle -> flush_IFID=1, instr_valid=0, next imem_addr=0x0100.
REQ-035 Fetch of 0xF000 at PC=0x0020 -> instr_valid=1 once with instr_out=0xF000, then halted=1, imem_req=0; later branch_taken=1 ignored; PC stays 0x0020.
REQ-036 PC=0xFFFE, ready -> pc_plus2_out=0x0000, next imem_addr=0x0000; rst asserted mid-WAIT -> imem_req drops immediately, refetch from RESET_PC after release.
